// File: rtl/axi_read_arbiter.sv
// axi_read_arbiter: two-master AXI read (AR+R) arbiter, single outstanding burst, round robin by default.
// Define AXI_RD_ARB_FIXED_PRIO_EN for fixed priority (master 0 wins ties).
module axi_read_arbiter #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                     aclk,
  input  logic                     areset,
  input  logic [ADDRESS_WIDTH-1:0] s0_araddr,
  input  logic [7:0]               s0_arlen,
  input  logic [2:0]               s0_arsize,
  input  logic [1:0]               s0_arburst,
  input  logic                     s0_arvalid,
  output logic                     s0_arready,
  output logic [DATA_WIDTH-1:0]    s0_rdata,
  output logic [1:0]               s0_rresp,
  output logic                     s0_rlast,
  output logic                     s0_rvalid,
  input  logic                     s0_rready,
  input  logic [ADDRESS_WIDTH-1:0] s1_araddr,
  input  logic [7:0]               s1_arlen,
  input  logic [2:0]               s1_arsize,
  input  logic [1:0]               s1_arburst,
  input  logic                     s1_arvalid,
  output logic                     s1_arready,
  output logic [DATA_WIDTH-1:0]    s1_rdata,
  output logic [1:0]               s1_rresp,
  output logic                     s1_rlast,
  output logic                     s1_rvalid,
  input  logic                     s1_rready,
  output logic [ADDRESS_WIDTH-1:0] m_araddr,
  output logic [7:0]               m_arlen,
  output logic [2:0]               m_arsize,
  output logic [1:0]               m_arburst,
  output logic                     m_arvalid,
  input  logic                     m_arready,
  input  logic [DATA_WIDTH-1:0]    m_rdata,
  input  logic [1:0]               m_rresp,
  input  logic                     m_rlast,
  input  logic                     m_rvalid,
  output logic                     m_rready,
  output logic                     grant,
  output logic                     busy,
  output logic                     proto_err
);
  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
  state_t                   state_q, state_d;
  logic                     grant_q, grant_d, proto_err_q, proto_err_d;
  logic [ADDRESS_WIDTH-1:0] araddr_q, araddr_d;
  logic [7:0]               arlen_q, arlen_d;
  logic [2:0]               arsize_q, arsize_d;
  logic [1:0]               arburst_q, arburst_d;
  logic [8:0]               cnt_q, cnt_d;
  logic                     win, ar_hs, beat, cnt_one, sel0, sel1;
`ifdef AXI_RD_ARB_FIXED_PRIO_EN
  assign win = ~s0_arvalid;
`else
  assign win = (s0_arvalid & s1_arvalid) ? ~grant_q : s1_arvalid;
`endif
  assign ar_hs   = (state_q == IDLE) & (s0_arvalid | s1_arvalid);
  assign beat    = (state_q == DATA) & m_rvalid & m_rready;
  assign cnt_one = cnt_q == 9'd1;
  assign sel0    = (state_q == DATA) & ~grant_q;
  assign sel1    = (state_q == DATA) & grant_q;
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q     <= IDLE;
      grant_q     <= 1'b1;
      proto_err_q <= 1'b0;
      araddr_q    <= '0;
      arlen_q     <= '0;
      arsize_q    <= '0;
      arburst_q   <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      proto_err_q <= proto_err_d;
      araddr_q    <= araddr_d;
      arlen_q     <= arlen_d;
      arsize_q    <= arsize_d;
      arburst_q   <= arburst_d;
      cnt_q       <= cnt_d;
    end
  end
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    proto_err_d = proto_err_q;
    araddr_d    = araddr_q;
    arlen_d     = arlen_q;
    arsize_d    = arsize_q;
    arburst_d   = arburst_q;
    cnt_d       = cnt_q;
    if (ar_hs) begin
      state_d   = ADDR;
      grant_d   = win;
      araddr_d  = win ? s1_araddr : s0_araddr;
      arlen_d   = win ? s1_arlen : s0_arlen;
      arsize_d  = win ? s1_arsize : s0_arsize;
      arburst_d = win ? s1_arburst : s0_arburst;
      cnt_d     = {1'b0, win ? s1_arlen : s0_arlen} + 9'd1;
    end
    if (state_q == ADDR && m_arready) state_d = DATA;
    if (beat) cnt_d = cnt_q - 9'd1;
    if (beat && (m_rlast || cnt_one)) state_d = IDLE;
    // rlast and the beat count must agree on the final beat
    if (beat && (m_rlast != cnt_one)) proto_err_d = 1'b1;
  end
  always_comb begin
    m_arvalid  = state_q == ADDR;
    m_araddr   = araddr_q;
    m_arlen    = arlen_q;
    m_arsize   = arsize_q;
    m_arburst  = arburst_q;
    m_rready   = (state_q == DATA) & (grant_q ? s1_rready : s0_rready);
    s0_arready = (state_q == IDLE) & s0_arvalid & ~win;
    s1_arready = (state_q == IDLE) & s1_arvalid & win;
    s0_rvalid  = sel0 & m_rvalid;
    s0_rdata   = sel0 ? m_rdata : '0;
    s0_rresp   = sel0 ? m_rresp : '0;
    s0_rlast   = sel0 & m_rlast;
    s1_rvalid  = sel1 & m_rvalid;
    s1_rdata   = sel1 ? m_rdata : '0;
    s1_rresp   = sel1 ? m_rresp : '0;
    s1_rlast   = sel1 & m_rlast;
    grant      = grant_q;
    busy       = state_q != IDLE;
    proto_err  = proto_err_q;
  end
endmodule
